// File: rtl/hcsr04_pkg.sv
// Shared types and timing constants for the HC-SR04 sensor-side responder.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG    = 3'd1,
    S_BURST   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } hcsr04_state_t;

  // Real-sensor timing for a 12 MHz clock.
  localparam int unsigned CYCLES_PER_CM_DEF   = 696;
  localparam int unsigned MIN_TRIG_CYCLES_DEF = 120;
  localparam int unsigned BURST_CYCLES_DEF    = 2400;
  localparam int unsigned MAX_CM_DEF          = 400;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 456000;
  localparam int unsigned HOLDOFF_CYCLES_DEF  = 120000;
  localparam int unsigned DIST_W_DEF          = 16;

  // Reduced timing so simulations finish in a few thousand cycles.
  localparam int unsigned SIM_CYCLES_PER_CM   = 4;
  localparam int unsigned SIM_MIN_TRIG_CYCLES = 10;
  localparam int unsigned SIM_BURST_CYCLES    = 20;
  localparam int unsigned SIM_MAX_CM          = 400;
  localparam int unsigned SIM_TIMEOUT_CYCLES  = 2000;
  localparam int unsigned SIM_HOLDOFF_CYCLES  = 50;
  localparam int unsigned SIM_DIST_W          = 16;

  // Larger of two constants, used to size the shared cycle counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchronizer for the asynchronous trigger with registered edge strobes.
module trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig_in,
  output logic trig_s,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next values: shift the input through two stages; strobes line up with the new trig_s level.
  always_comb begin
    s1_d   = trig_in;
    s2_d   = s1_q;
    rise_d = s1_q & ~s2_q;
    fall_d = ~s1_q & s2_q;
  end

  // Synchronizer and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign trig_s = s2_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/hcsr04_responder.sv
// Sensor-side HC-SR04 emulator: validates a trigger, waits out the burst, then
// returns an echo whose width encodes the latched distance.
module hcsr04_responder
  import hcsr04_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM   = CYCLES_PER_CM_DEF,
  parameter int unsigned MIN_TRIG_CYCLES = MIN_TRIG_CYCLES_DEF,
  parameter int unsigned BURST_CYCLES    = BURST_CYCLES_DEF,
  parameter int unsigned MAX_CM          = MAX_CM_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
  parameter int unsigned DIST_W          = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_in,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              trig_err,
  output logic              trig_ignored
);

  // One counter serves trigger width, burst, timeout echo and holdoff.
  localparam int unsigned CNT_MAX = max2(max2(TIMEOUT_CYCLES, HOLDOFF_CYCLES),
                                         max2(BURST_CYCLES, MIN_TRIG_CYCLES));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PRE_W   = $clog2(CYCLES_PER_CM + 1);

  hcsr04_state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic              range_ok_q, range_ok_d;
  logic              echo_q, echo_d;
  logic              busy_q, busy_d;
  logic              trig_err_q, trig_err_d;
  logic              trig_ignored_q, trig_ignored_d;

  logic trig_s, trig_rise, trig_fall;

  logic trig_ok_c, burst_done_c, cm_tick_c, echo_done_c, hold_done_c, dist_in_range_c;

  trig_sync u_trig_sync (
    .clk     (clk),
    .rst     (rst),
    .trig_in (trig_in),
    .trig_s  (trig_s),
    .rise    (trig_rise),
    .fall    (trig_fall)
  );

  assign trig_ok_c       = (cnt_q >= CNT_W'(MIN_TRIG_CYCLES));
  assign burst_done_c    = (cnt_q == CNT_W'(BURST_CYCLES - 1));
  assign cm_tick_c       = (presc_q == PRE_W'(CYCLES_PER_CM - 1));
  assign echo_done_c     = range_ok_q ? (cm_tick_c && (cm_q == DIST_W'(1)))
                                      : (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign hold_done_c     = (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1));
  assign dist_in_range_c = (distance_cm != '0) && (distance_cm <= DIST_W'(MAX_CM));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (trig_rise)    state_d = S_TRIG;
      S_TRIG:    if (trig_fall)    state_d = trig_ok_c ? S_BURST : S_IDLE;
      S_BURST:   if (burst_done_c) state_d = S_ECHO;
      S_ECHO:    if (echo_done_c)  state_d = S_HOLDOFF;
      S_HOLDOFF: if (hold_done_c)  state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Output next values; echo/busy follow the state being entered.
  always_comb begin
    echo_d         = (state_d == S_ECHO);
    busy_d         = (state_d != S_IDLE);
    trig_err_d     = (state_q == S_TRIG) && trig_fall && !trig_ok_c;
    trig_ignored_d = trig_rise && ((state_q == S_BURST) || (state_q == S_ECHO) ||
                                   (state_q == S_HOLDOFF));
  end

  // Counter, prescaler and distance latch updates.
  always_comb begin
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    cm_d       = cm_q;
    range_ok_d = range_ok_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig_rise) cnt_d = '0;
      end
      S_TRIG: begin
        if (trig_fall) begin
          cnt_d = '0;
          if (trig_ok_c) begin
            cm_d       = distance_cm;
            range_ok_d = dist_in_range_c;
          end
        end else if (trig_s && !trig_ok_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BURST: begin
        if (burst_done_c) begin
          cnt_d   = '0;
          presc_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ECHO: begin
        if (range_ok_q) begin
          if (cm_tick_c) begin
            presc_d = '0;
            cm_d    = cm_q - DIST_W'(1);
          end else begin
            presc_d = presc_q + PRE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (echo_done_c) begin
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      S_HOLDOFF: begin
        cnt_d = hold_done_c ? '0 : cnt_q + CNT_W'(1);
      end
      default: begin
        cnt_d   = '0;
        presc_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      presc_q        <= '0;
      cm_q           <= '0;
      range_ok_q     <= 1'b0;
      echo_q         <= 1'b0;
      busy_q         <= 1'b0;
      trig_err_q     <= 1'b0;
      trig_ignored_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      presc_q        <= presc_d;
      cm_q           <= cm_d;
      range_ok_q     <= range_ok_d;
      echo_q         <= echo_d;
      busy_q         <= busy_d;
      trig_err_q     <= trig_err_d;
      trig_ignored_q <= trig_ignored_d;
    end
  end

  assign echo         = echo_q;
  assign busy         = busy_q;
  assign trig_err     = trig_err_q;
  assign trig_ignored = trig_ignored_q;

endmodule
